// File: rtl/sap_controller.sv
// Control sequencer for the 8-bit bus machine: a six-T-state fetch/execute ring
// that decodes the opcode nibble into Moore control strobes for the bus registers.
module sap_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       carry,
  input  logic       zero,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] tstate
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JC  = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Encoding matches the reported T-state index so tstate is the state itself.
  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    HALT = 3'd7
  } state_t;

  state_t state;
  state_t state_next;
  logic   run;

  // The first edge after reset release is absorbed so T0 holds a full cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= T0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      T0: state_next = T1;
      T1: state_next = T2;
      T2: state_next = T3;
      T3: begin
        if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) state_next = T4;
        else if (opcode == OP_HLT) state_next = HALT;
        else state_next = T0;
      end
      T4: state_next = (opcode == OP_ADD || opcode == OP_SUB) ? T5 : T0;
      T5: state_next = T0;
      HALT: state_next = HALT;
      default: state_next = T0;
    endcase
  end

  // Strobes are forced low while rst is high so nothing partial leaks out.
  always_comb begin
    pc_inc   = 1'b0;
    pc_out   = 1'b0;
    pc_load  = 1'b0;
    mar_load = 1'b0;
    ram_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    b_load   = 1'b0;
    alu_out  = 1'b0;
    alu_sub  = 1'b0;
    out_load = 1'b0;
    halted   = 1'b0;
    tstate   = 3'd0;
    if (!rst) begin
      tstate = state;
      halted = (state == HALT);
      case (state)
        T0: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T1: pc_inc = 1'b1;
        T2: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
        end
        T3: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ir_out   = 1'b1;
              mar_load = 1'b1;
            end
            OP_JMP: begin
              ir_out  = 1'b1;
              pc_load = 1'b1;
            end
            OP_JC: begin
              ir_out  = carry;
              pc_load = carry;
            end
            OP_JZ: begin
              ir_out  = zero;
              pc_load = zero;
            end
            OP_OUT: begin
              a_out    = 1'b1;
              out_load = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_LDA) begin
            ram_out = 1'b1;
            a_load  = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ram_out = 1'b1;
            b_load  = 1'b1;
          end
        end
        T5: begin
          alu_out = 1'b1;
          a_load  = 1'b1;
          alu_sub = (opcode == OP_SUB);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_controller.sv
// Bench for sap_controller: instruction-length reference model with per-cycle
// compare, directed literal checks, and randomized opcode/flag/reset stimulus.
module tb_sap_controller;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic       carry;
  logic       zero;
  logic       pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out;
  logic       a_load, a_out, b_load, alu_out, alu_sub, out_load, halted;
  logic [2:0] tstate;

  sap_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .carry(carry), .zero(zero),
    .pc_inc(pc_inc), .pc_out(pc_out), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out(ram_out), .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load),
    .a_out(a_out), .b_load(b_load), .alu_out(alu_out), .alu_sub(alu_sub),
    .out_load(out_load), .halted(halted), .tstate(tstate)
  );

  localparam logic [12:0] PC_INC   = 13'h1000;
  localparam logic [12:0] PC_OUT   = 13'h0800;
  localparam logic [12:0] PC_LOAD  = 13'h0400;
  localparam logic [12:0] MAR_LOAD = 13'h0200;
  localparam logic [12:0] RAM_OUT  = 13'h0100;
  localparam logic [12:0] IR_LOAD  = 13'h0080;
  localparam logic [12:0] IR_OUT   = 13'h0040;
  localparam logic [12:0] A_LOAD   = 13'h0020;
  localparam logic [12:0] A_OUT    = 13'h0010;
  localparam logic [12:0] B_LOAD   = 13'h0008;
  localparam logic [12:0] ALU_OUT  = 13'h0004;
  localparam logic [12:0] ALU_SUB  = 13'h0002;
  localparam logic [12:0] OUT_LOAD = 13'h0001;

  logic [12:0] outs;
  assign outs = {pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out,
                 a_load, a_out, b_load, alu_out, alu_sub, out_load};

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a step counter within the current instruction, whose
  // length follows from the opcode; HLT parks after its fourth cycle.
  int   m_step;
  logic m_halted;
  logic m_armed;

  function automatic int instr_len(input logic [3:0] op);
    if (op == 4'h0) return 5;
    if (op == 4'h1 || op == 4'h2) return 6;
    return 4;
  endfunction

  function automatic logic [12:0] model_out(input int step, input logic [3:0] op,
                                            input logic c, input logic z);
    case (step)
      0: return PC_OUT | MAR_LOAD;
      1: return PC_INC;
      2: return RAM_OUT | IR_LOAD;
      3: case (op)
           4'h0, 4'h1, 4'h2: return IR_OUT | MAR_LOAD;
           4'h3: return IR_OUT | PC_LOAD;
           4'h4: return c ? (IR_OUT | PC_LOAD) : 13'h0;
           4'h5: return z ? (IR_OUT | PC_LOAD) : 13'h0;
           4'hE: return A_OUT | OUT_LOAD;
           default: return 13'h0;
         endcase
      4: return (op == 4'h0) ? (RAM_OUT | A_LOAD) : (RAM_OUT | B_LOAD);
      5: return ALU_OUT | A_LOAD | ((op == 4'h2) ? ALU_SUB : 13'h0);
      default: return 13'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_step   <= 0;
      m_halted <= 1'b0;
      m_armed  <= 1'b0;
    end else if (!m_armed) begin
      m_armed <= 1'b1;
    end else if (!m_halted) begin
      if (m_step == 3 && opcode == 4'hF) m_halted <= 1'b1;
      else if (m_step == instr_len(opcode) - 1) m_step <= 0;
      else m_step <= m_step + 1;
    end
  end

  // Per-cycle compare away from the active edge.
  always @(negedge clk) begin
    logic [12:0] e_outs;
    logic [2:0]  e_t;
    logic        e_h;
    if (rst) begin
      e_outs = 13'h0; e_t = 3'd0; e_h = 1'b0;
    end else if (m_halted) begin
      e_outs = 13'h0; e_t = 3'd7; e_h = 1'b1;
    end else begin
      e_outs = model_out(m_step, opcode, carry, zero);
      e_t = 3'(m_step);
      e_h = 1'b0;
    end
    checks++;
    if (outs !== e_outs) begin
      errors++;
      $display("FAIL cyc_outs t=%0t op=%h got=%h want=%h", $time, opcode, outs, e_outs);
    end
    checks++;
    if (tstate !== e_t) begin
      errors++;
      $display("FAIL cyc_tstate t=%0t got=%0d want=%0d", $time, tstate, e_t);
    end
    checks++;
    if (halted !== e_h) begin
      errors++;
      $display("FAIL cyc_halted t=%0t got=%b want=%b", $time, halted, e_h);
    end
    checks++;
    if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
      errors++;
      $display("FAIL bus_invariant t=%0t drivers=%b want at most one",
               $time, {pc_out, ram_out, ir_out, a_out, alu_out});
    end
  end

  task automatic check_lit(input string name, input logic [12:0] e_outs,
                           input logic [2:0] e_t, input logic e_h);
    checks++;
    if (outs !== e_outs || tstate !== e_t || halted !== e_h) begin
      errors++;
      $display("FAIL %s got outs=%h t=%0d h=%b want outs=%h t=%0d h=%b",
               name, outs, tstate, halted, e_outs, e_t, e_h);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; opcode = 4'h0; carry = 1'b0; zero = 1'b0;
    ticks(2);
    check_lit("reset_outs", 13'h0, 3'd0, 1'b0);

    // LDA after release: T0 held across the first edge, then 5-cycle instruction.
    rst = 1'b0;
    #1 check_lit("t0_after_release", PC_OUT | MAR_LOAD, 3'd0, 1'b0);
    tick(); check_lit("t0_held", PC_OUT | MAR_LOAD, 3'd0, 1'b0);
    tick(); check_lit("t1_fetch", PC_INC, 3'd1, 1'b0);
    tick(); check_lit("t2_fetch", RAM_OUT | IR_LOAD, 3'd2, 1'b0);
    tick(); check_lit("lda_t3", IR_OUT | MAR_LOAD, 3'd3, 1'b0);
    tick(); check_lit("lda_t4", RAM_OUT | A_LOAD, 3'd4, 1'b0);
    tick(); check_lit("lda_len", PC_OUT | MAR_LOAD, 3'd0, 1'b0);

    opcode = 4'h2;
    ticks(5); check_lit("sub_t5", ALU_OUT | A_LOAD | ALU_SUB, 3'd5, 1'b0);
    tick(); check_lit("sub_len", PC_OUT | MAR_LOAD, 3'd0, 1'b0);

    opcode = 4'h1;
    ticks(5); check_lit("add_t5", ALU_OUT | A_LOAD, 3'd5, 1'b0);
    tick(); check_lit("add_len", PC_OUT | MAR_LOAD, 3'd0, 1'b0);

    // Reset in the middle of ADD T4.
    ticks(4); check_lit("add_t4", RAM_OUT | B_LOAD, 3'd4, 1'b0);
    #2 rst = 1'b1;
    #1 check_lit("rst_mid_add", 13'h0, 3'd0, 1'b0);
    tick(); rst = 1'b0;
    #1 check_lit("restart_t0", PC_OUT | MAR_LOAD, 3'd0, 1'b0);
    tick();

    opcode = 4'h4; carry = 1'b0;
    ticks(3); check_lit("jc_nocarry", 13'h0, 3'd3, 1'b0);
    tick(); check_lit("jc_return", PC_OUT | MAR_LOAD, 3'd0, 1'b0);
    carry = 1'b1;
    ticks(3); check_lit("jc_carry", IR_OUT | PC_LOAD, 3'd3, 1'b0);
    tick();
    opcode = 4'h5; zero = 1'b0;
    ticks(3); check_lit("jz_nozero", 13'h0, 3'd3, 1'b0);
    tick();
    zero = 1'b1;
    ticks(3); check_lit("jz_zero", IR_OUT | PC_LOAD, 3'd3, 1'b0);
    tick();

    opcode = 4'hF;
    ticks(3); check_lit("hlt_t3", 13'h0, 3'd3, 1'b0);
    tick(); check_lit("halt_enter", 13'h0, 3'd7, 1'b1);
    ticks(22); check_lit("halt_hold", 13'h0, 3'd7, 1'b1);
    rst = 1'b1;
    #1 check_lit("halt_rst", 13'h0, 3'd0, 1'b0);
    tick(); rst = 1'b0;
    tick();

    // Randomized run: opcode changes only at instruction start, flags every cycle.
    for (int n = 0; n < 3000; n++) begin
      if (rst) rst = 1'b0;
      else if (m_halted && $urandom_range(0, 3) == 0) rst = 1'b1;
      if (!m_halted && m_step == 0) opcode = 4'($urandom_range(0, 15));
      carry = 1'($urandom);
      zero  = 1'($urandom);
      if (!rst && $urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap_controller.md
# sap_controller

Control sequencer for the 8-bit bus machine. It drives the `load` and `enable_output` strobes of the accumulator and every other bus-attached register. It runs a fetch/execute ring of up to six T-states per instruction, decodes the 4-bit opcode held in the instruction register, and asserts at most one bus driver per cycle. It sits directly upstream of the accumulator: `a_load` feeds the accumulator's `load`, and `a_out` feeds its `enable_output`.

## Interface
Parameters:
- none (opcode map fixed below)

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 4: upper nibble of the instruction register, valid from T3 onward.
- `carry` in 1: ALU carry flag, sampled combinationally in T3.
- `zero` in 1: ALU zero flag, sampled combinationally in T3.
- `pc_inc` out 1: increment program counter.
- `pc_out` out 1: PC drives bus.
- `pc_load` out 1: PC loads from bus.
- `mar_load` out 1: memory address register loads from bus.
- `ram_out` out 1: RAM drives bus.
- `ir_load` out 1: instruction register loads from bus.
- `ir_out` out 1: IR operand nibble drives bus.
- `a_load` out 1: accumulator `load`.
- `a_out` out 1: accumulator `enable_output`.
- `b_load` out 1: B register loads from bus.
- `alu_out` out 1: ALU result drives bus.
- `alu_sub` out 1: ALU subtract select.
- `out_load` out 1: output register loads from bus.
- `halted` out 1: high while in HALT.
- `tstate` out 3: current T-state index, 0–5; 7 in HALT.

## Operation
- States: T0–T5 plus HALT. Encoding is free; `tstate` must report the index.
- All control outputs are Moore-decoded from state and `opcode`. They are combinational, with no extra register stage.
- Fetch, identical for every opcode:
  - T0: `pc_out`, `mar_load`
  - T1: `pc_inc`
  - T2: `ram_out`, `ir_load`
- Execute, by opcode:
  - LDA 0x0:
    - T3: `ir_out`, `mar_load`
    - T4: `ram_out`, `a_load`
    - next state is T0
  - ADD 0x1:
    - T3: `ir_out`, `mar_load`
    - T4: `ram_out`, `b_load`
    - T5: `alu_out`, `a_load`
    - next state is T0
  - SUB 0x2:
    - same as ADD, plus `alu_sub` in T5
  - JMP 0x3:
    - T3: `ir_out`, `pc_load`
    - next state is T0
  - JC 0x4:
    - T3: `ir_out`, `pc_load` only if `carry`=1; otherwise no outputs
    - next state is T0
  - JZ 0x5:
    - as JC, gated by `zero`
  - OUT 0xE:
    - T3: `a_out`, `out_load`
    - next state is T0
  - HLT 0xF:
    - T3: no outputs
    - next state is HALT
  - any other opcode:
    - NOP; T3 has no outputs
    - next state is T0
- Instruction length: LDA 5 cycles, ADD/SUB 6, all others 4. Short instructions return directly from T3 or T4 to T0 with no idle T-states.
- HALT:
  - all control outputs are 0 and `halted`=1
  - the block stays in HALT until `rst`
- Bus invariant: at most one of `pc_out`, `ram_out`, `ir_out`, `a_out`, `alu_out` is high in any cycle, in any state.

## Timing
- `rst`=1 takes effect immediately, regardless of `clk`:
  - state goes to T0
  - all control outputs are forced to 0, `halted`=0, `tstate`=0
- First rising edge after `rst` deasserts: the block is in T0 with the T0 outputs active, and advances to T1 on that edge's successor. Concretely, T0 outputs are visible for the full first cycle after release.
- Each state lasts exactly one `clk` cycle.
- Consumers sample strobes on the rising edge that ends the state.
- `opcode`, `carry` and `zero` may change at any time before T3. Only their values during T3–T5 matter.
- Reset in mid-instruction, in any state including HALT: the block abandons the instruction. It emits no partial strobes after `rst` rises, and restarts at T0.
- The T-state counter never wraps past T5. T5 always returns to T0.

## Test plan
- Reset release:
  - assert `rst` in mid-cycle → all outputs 0 immediately
  - release → T0 with `pc_out`=1, `mar_load`=1
  - T1 `pc_inc`=1, T2 `ram_out`+`ir_load`=1
- LDA (`opcode`=0x0) → T3 `ir_out`+`mar_load`, T4 `ram_out`+`a_load`, then `tstate`=0 on the 6th cycle (5 cycles per instruction).
- SUB (`opcode`=0x2) → T5 has `alu_out`+`a_load`+`alu_sub`=1. With ADD (0x1), `alu_sub` stays 0 throughout. Both take 6 cycles.
- JC with `carry`=0 → no outputs in T3, back to T0. JC with `carry`=1 → `ir_out`+`pc_load` in T3. JZ checked the same way with `zero`.
- HLT (0xF) → HALT after T3:
  - `halted`=1, `tstate`=7, all strobes 0 for 20+ cycles
  - `rst` pulse → T0
- Assert `rst` during T4 of ADD → `b_load` drops immediately; after release, the fetch restarts at T0.
- In every test, check the bus invariant on every cycle: never two drivers high at once.
